id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/data width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock for all state, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port instruction_id  input  INSTR_W  decoded instruction from the register-file stage.
REQ-006 SHALL have port valid_id  input  1  instruction_id is real (not empty slot).
REQ-007 SHALL have ports reg_rnValue, reg_rmValue  input  DATA_W  register-file read data for Rn and Rm.
REQ-008 SHALL have port flush  input  1  taken branch; kill the instruction entering EX.
REQ-009 SHALL have port mem_busy  input  1  downstream not ready; freeze EX contents.
REQ-010 SHALL have port instruction_reg_file  output  INSTR_W  registered instruction in EX, feeding the forwarding unit and ALU.
REQ-011 SHALL have ports rnValue_ex, rmValue_ex  output  DATA_W  registered operands in EX.
REQ-012 SHALL have port valid_ex  output  1  EX slot holds a committable instruction.
REQ-013 SHALL have port stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-014 SHALL have port stall_count  output  16  saturating count of load-use bubbles inserted.

Function
REQ-015 SHALL decode fields Rn=[19:16], Rd=[15:12], Rm=[3:0], type=[27:26], I=[25], opcode=[24:21], L=[20].
REQ-016 SHALL classify the EX-slot instruction as a load when valid_ex=1, type=01, L=1.
REQ-017 SHALL treat instruction_id as using Rn when valid_id=1, type is 00 or 01, and not (type=00 and opcode is 1101 MOV or 1111 MVN).
REQ-018 SHALL treat instruction_id as using Rm when valid_id=1 and (type=00, I=0) or (type=01, I=1); type 10 uses neither.
REQ-019 SHALL raise load_use when the EX slot is a load and its Rd equals a used Rn or used Rm of instruction_id.
REQ-020 SHALL drive stall = load_use OR mem_busy, combinationally, same cycle.
REQ-021 SHALL update the EX slot each rising edge with priority: reset > flush > mem_busy > load_use > normal.
REQ-022 flush: SHALL load BUBBLE_INSTR, valid_ex=0, operands zero, regardless of mem_busy or load_use.
REQ-023 mem_busy (no flush): SHALL hold all EX-slot registers unchanged; stall_count unchanged.
REQ-024 load_use (no flush, no mem_busy): SHALL load BUBBLE_INSTR, valid_ex=0, operands zero; stall_count increments.
REQ-025 normal: SHALL load instruction_id, reg_rnValue, reg_rmValue, valid_id with one-cycle latency.
REQ-026 BUBBLE_INSTR SHALL be 32'hE150_0000 (CMP r0,r0), a non-writing opcode, so forwarding never selects it; EX SHALL commit no flags or results when valid_ex=0.
REQ-027 A load-use bubble SHALL last exactly one cycle: the cycle after a bubble the EX slot is not a load, so load_use deasserts and the held instruction advances.
REQ-028 stall_count SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-029 On reset=1 at a clock edge: instruction_reg_file=BUBBLE_INSTR, rnValue_ex=0, rmValue_ex=0, valid_ex=0, stall_count=0; reset overrides flush and mem_busy.
REQ-030 Reset asserted mid-stall SHALL clear the pending bubble; stall depends only on inputs and the reset EX slot, so it is 0 the cycle after reset unless mem_busy=1.

Structure
REQ-031 Package pipe_pkg SHALL hold BUBBLE_INSTR, field bit positions, type codes (00 data-proc, 01 load/store, 10 branch) and opcode constants MOV, MVN, CMP, CMN, TST, TEQ.
REQ-032 Combinational load-use detection SHALL be a sub-module hazard_detect (inputs: EX instruction, valid_ex, instruction_id, valid_id; output load_use).
REQ-033 The EX-slot registers and stall_count SHALL live in id_ex_stage itself.

Verification
REQ-034 Normal advance: valid_id=1, instruction_id=ADD r3,r1,r2, rn=5, rm=7 -> next cycle instruction_reg_file=that ADD, rnValue_ex=5, rmValue_ex=7, valid_ex=1, stall=0.
REQ-035 Load-use: EX holds LDR r4,[r1]; ID holds ADD r5,r4,r2 -> stall=1 that cycle; next cycle EX=32'hE150_0000, valid_ex=0, stall_count=1; following cycle ADD enters EX.
REQ-036 No false stall: EX holds LDR r4; ID holds MOV r5,r4-as-Rn-field (MOV ignores Rn) or branch -> stall=0, no bubble.
REQ-037 Flush over load-use and mem_busy: flush=1, load_use=1, mem_busy=1 same cycle -> EX=BUBBLE_INSTR, valid_ex=0, stall_count unchanged.
REQ-038 mem_busy hold: mem_busy=1 for 3 cycles with changing instruction_id -> EX outputs constant, stall=1 throughout; release loads current instruction_id.
REQ-039 Saturation and reset: preload stall_count to 16'hFFFE, force two load-use bubbles -> 16'hFFFF and held; reset=1 -> all outputs at REQ-029 values next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: instruction field positions, type codes, opcodes
// and the bubble word injected into EX on flushes and load-use stalls.
package pipe_pkg;

  localparam logic [31:0] BUBBLE_INSTR = 32'hE150_0000;

  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;
  localparam int RM_LSB   = 0;
  localparam int TYPE_LSB = 26;
  localparam int I_BIT    = 25;
  localparam int OPC_LSB  = 21;
  localparam int L_BIT    = 20;

  typedef enum logic [1:0] {
    TYPE_DP = 2'b00,
    TYPE_LS = 2'b01,
    TYPE_BR = 2'b10
  } instr_type_e;

  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef struct packed {
    instr_type_e itype;
    logic        imm;
    logic [3:0]  opcode;
    logic        load;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
  } fields_t;

  function automatic fields_t decode(input logic [31:0] instr);
    fields_t f;
    f.itype  = instr_type_e'(instr[TYPE_LSB +: 2]);
    f.imm    = instr[I_BIT];
    f.opcode = instr[OPC_LSB +: 4];
    f.load   = instr[L_BIT];
    f.rn     = instr[RN_LSB +: 4];
    f.rd     = instr[RD_LSB +: 4];
    f.rm     = instr[RM_LSB +: 4];
    return f;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags when the load sitting in EX writes
// a register that the instruction in ID actually reads.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instruction_ex,
  input  logic               valid_ex,
  input  logic [INSTR_W-1:0] instruction_id,
  input  logic               valid_id,
  output logic               load_use
);

  fields_t ex_f;
  fields_t id_f;
  logic    ex_is_load;
  logic    uses_rn;
  logic    uses_rm;
  logic    unused_fields;

  assign ex_f = decode(instruction_ex[31:0]);
  assign id_f = decode(instruction_id[31:0]);

  assign ex_is_load = valid_ex && (ex_f.itype == TYPE_LS) && ex_f.load;

  // MOV/MVN carry a don't-care Rn field, so it must not create a dependency.
  assign uses_rn = valid_id
                && ((id_f.itype == TYPE_DP) || (id_f.itype == TYPE_LS))
                && !((id_f.itype == TYPE_DP)
                     && ((id_f.opcode == OP_MOV) || (id_f.opcode == OP_MVN)));

  assign uses_rm = valid_id
                && (((id_f.itype == TYPE_DP) && !id_f.imm)
                 || ((id_f.itype == TYPE_LS) &&  id_f.imm));

  assign load_use = ex_is_load
                 && ((uses_rn && (ex_f.rd == id_f.rn))
                  || (uses_rm && (ex_f.rd == id_f.rm)));

  assign unused_fields = ^{ex_f, id_f, instruction_ex, instruction_id};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// back-pressure hold and a saturating count of inserted bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction_id,
  input  logic               valid_id,
  input  logic [DATA_W-1:0]  reg_rnValue,
  input  logic [DATA_W-1:0]  reg_rmValue,
  input  logic               flush,
  input  logic               mem_busy,
  output logic [INSTR_W-1:0] instruction_reg_file,
  output logic [DATA_W-1:0]  rnValue_ex,
  output logic [DATA_W-1:0]  rmValue_ex,
  output logic               valid_ex,
  output logic               stall,
  output logic [15:0]        stall_count
);

  localparam logic [INSTR_W-1:0] BUBBLE = INSTR_W'(BUBBLE_INSTR);

  logic [INSTR_W-1:0] instr_reg;
  logic [DATA_W-1:0]  rn_reg;
  logic [DATA_W-1:0]  rm_reg;
  logic               valid_reg;
  logic [15:0]        stall_count_reg;
  logic               load_use;

  hazard_detect #(
    .INSTR_W (INSTR_W)
  ) u_hazard (
    .instruction_ex (instr_reg),
    .valid_ex       (valid_reg),
    .instruction_id (instruction_id),
    .valid_id       (valid_id),
    .load_use       (load_use)
  );

  assign stall = load_use | mem_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg       <= BUBBLE;
      rn_reg          <= '0;
      rm_reg          <= '0;
      valid_reg       <= 1'b0;
      stall_count_reg <= '0;
    end else if (flush) begin
      instr_reg <= BUBBLE;
      rn_reg    <= '0;
      rm_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (!mem_busy) begin
      if (load_use) begin
        // A bubble is never a load, so the stall clears on the next cycle.
        instr_reg <= BUBBLE;
        rn_reg    <= '0;
        rm_reg    <= '0;
        valid_reg <= 1'b0;
        if (stall_count_reg != 16'hFFFF) begin
          stall_count_reg <= stall_count_reg + 16'd1;
        end
      end else begin
        instr_reg <= instruction_id;
        rn_reg    <= reg_rnValue;
        rm_reg    <= reg_rmValue;
        valid_reg <= valid_id;
      end
    end
  end

  assign instruction_reg_file = instr_reg;
  assign rnValue_ex           = rn_reg;
  assign rmValue_ex           = rm_reg;
  assign valid_ex             = valid_reg;
  assign stall_count          = stall_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a source-register
// mask reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_id;
  logic        valid_id;
  logic [15:0] reg_rnValue;
  logic [15:0] reg_rmValue;
  logic        flush;
  logic        mem_busy;
  logic [31:0] instruction_reg_file;
  logic [15:0] rnValue_ex;
  logic [15:0] rmValue_ex;
  logic        valid_ex;
  logic        stall;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;

  // reference EX slot
  logic [31:0] m_instr;
  logic [15:0] m_rn;
  logic [15:0] m_rm;
  logic        m_valid;
  int          m_cnt;

  localparam logic [31:0] BUB      = 32'hE150_0000;
  localparam logic [31:0] ADD_3_12 = 32'hE081_3002;
  localparam logic [31:0] LDR_4_1  = 32'hE591_4000;
  localparam logic [31:0] ADD_5_42 = 32'hE084_5002;
  localparam logic [31:0] MOV_5_N4 = 32'hE1A4_5001;
  localparam logic [31:0] B_FWD    = 32'hEA00_0004;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(16), .INSTR_W(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction_id       (instruction_id),
    .valid_id             (valid_id),
    .reg_rnValue          (reg_rnValue),
    .reg_rmValue          (reg_rmValue),
    .flush                (flush),
    .mem_busy             (mem_busy),
    .instruction_reg_file (instruction_reg_file),
    .rnValue_ex           (rnValue_ex),
    .rmValue_ex           (rmValue_ex),
    .valid_ex             (valid_ex),
    .stall                (stall),
    .stall_count          (stall_count)
  );

  // set of architectural registers the instruction reads
  function automatic logic [15:0] src_mask(input logic [31:0] w, input logic v);
    logic [15:0] m;
    m = '0;
    if (v) begin
      case (w[27:26])
        2'b00: begin
          if (!(w[24:21] inside {4'hD, 4'hF})) m[w[19:16]] = 1'b1;
          if (!w[25]) m[w[3:0]] = 1'b1;
        end
        2'b01: begin
          m[w[19:16]] = 1'b1;
          if (w[25]) m[w[3:0]] = 1'b1;
        end
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  function automatic logic model_hazard();
    logic [15:0] m;
    m = src_mask(instruction_id, valid_id);
    return m_valid && (m_instr[27:26] == 2'b01) && m_instr[20] && m[m_instr[15:12]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_bubble();
    m_instr = BUB;
    m_rn    = '0;
    m_rm    = '0;
    m_valid = 1'b0;
  endtask

  task automatic step();
    logic lu;
    #2;
    lu = model_hazard();
    chk("stall", {31'd0, stall}, {31'd0, lu | mem_busy});
    @(posedge clk);
    if (reset) begin
      set_bubble();
      m_cnt = 0;
    end else if (flush) begin
      set_bubble();
    end else if (!mem_busy) begin
      if (lu) begin
        set_bubble();
        m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      end else begin
        m_instr = instruction_id;
        m_rn    = reg_rnValue;
        m_rm    = reg_rmValue;
        m_valid = valid_id;
      end
    end
    #1;
    chk("instr_ex", instruction_reg_file, m_instr);
    chk("rn_ex", {16'd0, rnValue_ex}, {16'd0, m_rn});
    chk("rm_ex", {16'd0, rmValue_ex}, {16'd0, m_rm});
    chk("valid_ex", {31'd0, valid_ex}, {31'd0, m_valid});
    chk("stall_count", {16'd0, stall_count}, m_cnt[31:0]);
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic [15:0] rn,
                       input logic [15:0] rm);
    instruction_id = ins;
    valid_id       = v;
    reg_rnValue    = rn;
    reg_rmValue    = rm;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [1:0] ty;
    ty = 2'($urandom_range(0, 2));
    return {4'hE, ty, 1'($urandom), 4'($urandom), 1'($urandom),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'h00,
            4'($urandom_range(0, 3))};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; mem_busy = 1'b0;
    drive(32'h0, 1'b0, 16'h0, 16'h0);
    set_bubble();
    m_cnt = 0;
    @(posedge clk); #1;

    // reset state
    step();
    reset = 1'b0;

    // normal advance
    drive(ADD_3_12, 1'b1, 16'd5, 16'd7);
    step();

    // load-use bubble then the held ADD advances
    drive(LDR_4_1, 1'b1, 16'h0011, 16'h0022);
    step();
    drive(ADD_5_42, 1'b1, 16'h0033, 16'h0044);
    step();
    step();

    // no false stall for MOV with Rn field matching, nor for branch
    drive(LDR_4_1, 1'b1, 16'h1, 16'h2);
    step();
    drive(MOV_5_N4, 1'b1, 16'h3, 16'h4);
    step();
    drive(LDR_4_1, 1'b1, 16'h5, 16'h6);
    step();
    drive(B_FWD, 1'b1, 16'h7, 16'h8);
    step();

    // flush beats load-use and mem_busy
    drive(LDR_4_1, 1'b1, 16'h9, 16'hA);
    step();
    drive(ADD_5_42, 1'b1, 16'hB, 16'hC);
    flush = 1'b1; mem_busy = 1'b1;
    step();
    flush = 1'b0; mem_busy = 1'b0;

    // mem_busy hold for three cycles with changing ID, then release
    drive(ADD_3_12, 1'b1, 16'h100, 16'h200);
    step();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(rand_instr(), 1'b1, 16'($urandom), 16'($urandom));
      step();
    end
    mem_busy = 1'b0;
    drive(ADD_5_42, 1'b1, 16'h1234, 16'h5678);
    step();

    // saturation from a preloaded count
    force dut.stall_count_reg = 16'hFFFE;
    m_cnt = 32'hFFFE;
    #2;
    release dut.stall_count_reg;
    for (int i = 0; i < 3; i++) begin
      drive(LDR_4_1, 1'b1, 16'h1, 16'h2);
      step();
      drive(ADD_5_42, 1'b1, 16'h3, 16'h4);
      step();
      step();
    end

    // reset in the middle of a stall
    drive(LDR_4_1, 1'b1, 16'h1, 16'h2);
    step();
    drive(ADD_5_42, 1'b1, 16'h3, 16'h4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      drive(rand_instr(), ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
